vga_scanout: RTL and testbench



---
 rtl/vga_scanout_if.sv | 13 +
 rtl/vga_scanout.sv | 133 +++++++++++++
 tb/tb_vga_scanout.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_scanout_if.sv
// Framebuffer read port between the VGA scanout (master) and the pixel RAM (slave).
// Protocol: rd_en qualifies rd_addr in the same cycle; the RAM returns rd_data for that
// address one clock later. There is no backpressure: the scanout reads at pixel rate.
interface vga_scanout_if #(
   parameter int ADDR_W = 19
);
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic [8:0]        rd_data;

   modport master (output rd_addr, output rd_en, input rd_data);
   modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/vga_scanout.sv
// Raster-order framebuffer reader driving the VGA DAC at 640x480@60 Hz from a 50 MHz clock.
// Pixel rate is half the system clock; outputs trail the counters by one pixel (RAM latency).
module vga_scanout #(
   parameter int nX     = 10,
   parameter int nY     = 9,
   parameter int ADDR_W = 19,
   parameter int H_VIS  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_VIS  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic          clock,
   input  logic          reset,
   vga_scanout_if.master fb,
   output logic [7:0]    VGA_R,
   output logic [7:0]    VGA_G,
   output logic [7:0]    VGA_B,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_BLANK_N,
   output logic          VGA_SYNC_N,
   output logic          VGA_CLK,
   output logic          vblank,
   output logic          frame_start
);
   // The line counter needs one more bit than nY to hold 0..524.
   localparam int CW    = (nX > nY + 1) ? nX : nY + 1;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_VIS_C   = CW'(H_VIS);
   localparam logic [CW-1:0] H_SYNC_LO = CW'(H_VIS + H_FP);
   localparam logic [CW-1:0] H_SYNC_HI = CW'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] H_LAST    = CW'(H_TOT - 1);
   localparam logic [CW-1:0] V_VIS_C   = CW'(V_VIS);
   localparam logic [CW-1:0] V_SYNC_LO = CW'(V_VIS + V_FP);
   localparam logic [CW-1:0] V_SYNC_HI = CW'(V_VIS + V_FP + V_SYNC - 1);
   localparam logic [CW-1:0] V_LAST    = CW'(V_TOT - 1);

   logic              r_pix_en;
   logic [CW-1:0]     r_h;
   logic [CW-1:0]     r_v;
   logic              r_hs;
   logic              r_vs;
   logic              r_blank_n;
   logic              r_vblank;
   logic              r_frame_start;
   logic              r_vga_clk;
   logic [7:0]        r_red;
   logic [7:0]        r_grn;
   logic [7:0]        r_blu;

   logic              w_tick;
   logic              w_h_last;
   logic              w_v_last;
   logic              w_vis;
   logic [ADDR_W-1:0] w_addr;

   function automatic logic [7:0] f_expand(input logic [2:0] c);
      return {c, c, c[2:1]};
   endfunction

   assign w_tick   = r_pix_en;
   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);
   assign w_vis    = (r_h < H_VIS_C) && (r_v < V_VIS_C);

   // For the 640-wide default this is (v<<9)+(v<<7)+h; the constant multiply reduces to that.
   assign w_addr     = ADDR_W'(r_v) * ADDR_W'(H_VIS) + ADDR_W'(r_h);
   assign fb.rd_addr = w_vis ? w_addr : '0;
   assign fb.rd_en   = w_vis;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_pix_en <= 1'b0;
         r_h      <= '0;
         r_v      <= '0;
      end else begin
         r_pix_en <= ~r_pix_en;
         if (w_tick) begin
            if (w_h_last) begin
               r_h <= '0;
               r_v <= w_v_last ? '0 : r_v + 1'b1;
            end else begin
               r_h <= r_h + 1'b1;
            end
         end
      end
   end

   // Registered on tick edges from the counter decode plus the word the RAM fetched for it.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_hs          <= 1'b1;
         r_vs          <= 1'b1;
         r_blank_n     <= 1'b0;
         r_vblank      <= 1'b0;
         r_red         <= 8'h00;
         r_grn         <= 8'h00;
         r_blu         <= 8'h00;
         r_vga_clk     <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_vga_clk     <= ~r_pix_en;
         r_frame_start <= w_tick && w_h_last && w_v_last;
         if (w_tick) begin
            r_hs      <= ~((r_h >= H_SYNC_LO) && (r_h <= H_SYNC_HI));
            r_vs      <= ~((r_v >= V_SYNC_LO) && (r_v <= V_SYNC_HI));
            r_blank_n <= w_vis;
            r_vblank  <= (r_v >= V_VIS_C);
            r_red     <= w_vis ? f_expand(fb.rd_data[8:6]) : 8'h00;
            r_grn     <= w_vis ? f_expand(fb.rd_data[5:3]) : 8'h00;
            r_blu     <= w_vis ? f_expand(fb.rd_data[2:0]) : 8'h00;
         end
      end
   end

   assign VGA_R       = r_red;
   assign VGA_G       = r_grn;
   assign VGA_B       = r_blu;
   assign VGA_HS      = r_hs;
   assign VGA_VS      = r_vs;
   assign VGA_BLANK_N = r_blank_n;
   assign VGA_SYNC_N  = 1'b0;
   assign VGA_CLK     = r_vga_clk;
   assign vblank      = r_vblank;
   assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout: a shrunken-geometry instance checked pixel by pixel against a
// raster model, and a full 640x480 instance checked for line timing and address/colour.
module tb_vga_scanout;
   localparam int SH_VIS  = 20;
   localparam int SH_FP   = 4;
   localparam int SH_SYNC = 6;
   localparam int SH_BP   = 6;
   localparam int SV_VIS  = 12;
   localparam int SV_FP   = 3;
   localparam int SV_SYNC = 2;
   localparam int SV_BP   = 3;
   localparam int SH_TOT  = SH_VIS + SH_FP + SH_SYNC + SH_BP;
   localparam int SV_TOT  = SV_VIS + SV_FP + SV_SYNC + SV_BP;
   localparam int S_FRAME = SH_TOT * SV_TOT;
   localparam int S_PIX   = SH_VIS * SV_VIS;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic rst_s = 1'b1;
   logic rst_f = 1'b1;
   always #5 clock = ~clock;

   vga_scanout_if #(.ADDR_W(19)) fb_s ();
   vga_scanout_if #(.ADDR_W(19)) fb_f ();

   logic [7:0] r_s, g_s, b_s, r_f, g_f, b_f;
   logic hs_s, vs_s, bn_s, sn_s, vc_s, vb_s, fs_s;
   logic hs_f, vs_f, bn_f, sn_f, vc_f, vb_f, fs_f;

   vga_scanout #(
      .ADDR_W(19),
      .H_VIS(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
      .V_VIS(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
   ) dut_s (
      .clock(clock), .reset(rst_s), .fb(fb_s),
      .VGA_R(r_s), .VGA_G(g_s), .VGA_B(b_s),
      .VGA_HS(hs_s), .VGA_VS(vs_s), .VGA_BLANK_N(bn_s), .VGA_SYNC_N(sn_s),
      .VGA_CLK(vc_s), .vblank(vb_s), .frame_start(fs_s)
   );

   vga_scanout dut_f (
      .clock(clock), .reset(rst_f), .fb(fb_f),
      .VGA_R(r_f), .VGA_G(g_f), .VGA_B(b_f),
      .VGA_HS(hs_f), .VGA_VS(vs_f), .VGA_BLANK_N(bn_f), .VGA_SYNC_N(sn_f),
      .VGA_CLK(vc_f), .vblank(vb_f), .frame_start(fs_f)
   );

   // ---------------- RAM models (1-clock read latency) ----------------
   logic [8:0] mem_s [S_PIX];

   always @(posedge clock) begin
      if (fb_s.rd_addr < 19'(S_PIX)) fb_s.rd_data <= mem_s[int'(fb_s.rd_addr)];
      else                           fb_s.rd_data <= 9'h000;
      fb_f.rd_data <= fb_f.rd_addr[8:0];
   end

   // ---------------- check bookkeeping ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // 3-bit level scaled to 8 bits: c*36 + c/2 equals bit replication {c,c,c[2:1]}.
   function automatic logic [7:0] grow(input logic [2:0] c);
      int ci;
      ci = int'(c);
      return 8'(ci * 36 + ci / 2);
   endfunction

   // Expected {hs, vs, blank_n, vblank, R, G, B} for the p-th pixel shown since reset.
   function automatic logic [27:0] model_px_s(input int p);
      int q, h, v;
      bit vis;
      logic [8:0] d;
      q   = p % S_FRAME;
      h   = q % SH_TOT;
      v   = q / SH_TOT;
      vis = (h < SH_VIS) && (v < SV_VIS);
      d   = vis ? mem_s[v * SH_VIS + h] : 9'h000;
      return {!(h >= SH_VIS + SH_FP && h < SH_VIS + SH_FP + SH_SYNC),
              !(v >= SV_VIS + SV_FP && v < SV_VIS + SV_FP + SV_SYNC),
              vis, (v >= SV_VIS), grow(d[8:6]), grow(d[5:3]), grow(d[2:0])};
   endfunction

   // ---------------- small instance: scoreboard producer ----------------
   int          k_s = 0;
   bit          rst_s_edge = 1'b1;
   logic [59:0] exp_q[$];

   always @(posedge clock) begin
      rst_s_edge = rst_s;
      if (rst_s) begin
         k_s = 0;
      end else begin
         k_s++;
         if (k_s % 2 == 0) exp_q.push_back({32'(k_s / 2 - 1), model_px_s(k_s / 2 - 1)});
      end
   end

   // ---------------- small instance: monitor ----------------
   bit prev_vc_s = 1'b0;

   always @(negedge clock) begin : mon_s
      int q, h, v;
      bit vis;
      logic [59:0] e;
      q   = (k_s / 2) % S_FRAME;
      h   = q % SH_TOT;
      v   = q / SH_TOT;
      vis = (h < SH_VIS) && (v < SV_VIS);
      chk("s_rd_addr", fb_s.rd_addr, vis ? 19'(v * SH_VIS + h) : 19'd0);
      chk("s_rd_en", fb_s.rd_en, vis);
      if (rst_s_edge) begin
         chk("s_reset_outputs", {hs_s, vs_s, bn_s, r_s, g_s, b_s, vc_s, vb_s, fs_s, sn_s},
             {3'b110, 24'h000000, 4'b0000});
      end else begin
         chk("s_frame_start", fs_s, (k_s % 2 == 0) && (k_s > 0) && ((k_s / 2) % S_FRAME == 0));
         if (!vc_s && prev_vc_s) begin
            chk("s_pixel_queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk($sformatf("s_pixel_%0d", e[59:28]),
                   {hs_s, vs_s, bn_s, vb_s, r_s, g_s, b_s}, e[27:0]);
            end
         end
      end
      prev_vc_s = vc_s;
   end

   // ---------------- full instance: timing, address and colour ----------------
   int k_f = 0;
   bit rst_f_edge = 1'b1;
   bit prev_vc_f = 1'b0, prev_hs_f = 1'b1, prev_bn_f = 1'b0;
   bit have_fall_f = 1'b0, seen_bn_f = 1'b0;
   int last_fall_f = 0, rise_bn_f = 0, hs_falls_f = 0;

   always @(posedge clock) begin
      rst_f_edge = rst_f;
      if (rst_f) k_f = 0;
      else       k_f++;
   end

   always @(negedge clock) begin : mon_f
      int q, h, v, p;
      bit vis;
      logic [18:0] a;
      q   = k_f / 2;
      h   = q % 800;
      v   = (q / 800) % 525;
      vis = (h < 640) && (v < 480);
      chk("f_rd_addr", fb_f.rd_addr, vis ? 19'(v * 640 + h) : 19'd0);
      chk("f_rd_en", fb_f.rd_en, vis);
      if (rst_f_edge) begin
         chk("f_reset_outputs", {hs_f, vs_f, bn_f, r_f, g_f, b_f, vc_f, vb_f, fs_f, sn_f},
             {3'b110, 24'h000000, 4'b0000});
         prev_hs_f   = 1'b1;
         prev_bn_f   = 1'b0;
         have_fall_f = 1'b0;
         seen_bn_f   = 1'b0;
         hs_falls_f  = 0;
      end else begin
         if (!vc_f && prev_vc_f) begin
            p   = k_f / 2 - 1;
            h   = p % 800;
            v   = p / 800;
            vis = (h < 640) && (v < 480);
            a   = 19'(v * 640 + h);
            chk($sformatf("f_rgb_%0d_%0d", h, v), {r_f, g_f, b_f},
                vis ? {grow(a[8:6]), grow(a[5:3]), grow(a[2:0])} : 24'h0);
         end
         if (!hs_f && prev_hs_f) begin
            if (!have_fall_f) chk("f_hs_first_fall", k_f, 1314);
            else              chk("f_hs_period", k_f - last_fall_f, 1600);
            have_fall_f = 1'b1;
            last_fall_f = k_f;
            hs_falls_f++;
         end
         if (hs_f && !prev_hs_f && have_fall_f) chk("f_hs_low", k_f - last_fall_f, 192);
         if (bn_f && !prev_bn_f) begin
            if (!seen_bn_f) chk("f_blank_first_rise", k_f, 2);
            seen_bn_f = 1'b1;
            rise_bn_f = k_f;
         end
         if (!bn_f && prev_bn_f) chk("f_blank_high", k_f - rise_bn_f, 1280);
         prev_hs_f = hs_f;
         prev_bn_f = bn_f;
      end
      prev_vc_f = vc_f;
   end

   // ---------------- driver ----------------
   initial begin
      for (int i = 0; i < S_PIX; i++) mem_s[i] = 9'($urandom_range(0, 511));
      mem_s[0] = 9'b111_000_101;
      mem_s[7] = 9'b111_000_101;
      repeat (3) @(posedge clock);
      #1;
      rst_s = 1'b0;
      rst_f = 1'b0;
      repeat ($urandom_range(2900, 3900)) @(posedge clock);
      #1 rst_f = 1'b1;
      @(posedge clock);
      #1 rst_f = 1'b0;
      repeat ($urandom_range(50, 400)) @(posedge clock);
      #1 rst_s = 1'b1;
      @(posedge clock);
      #1 rst_s = 1'b0;
      repeat (5200) @(posedge clock);
      @(negedge clock);
      #1;
      chk("s_queue_drained", exp_q.size(), 0);
      chk("f_hs_fall_count_ge3", hs_falls_f >= 3, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
